// File: rtl/weight_bit_serializer.sv
// Weight-side bit-plane serializer: takes M signed Pw-bit weights in parallel and emits them
// LSB plane first, one plane per cycle. Define WBS_DOUBLE_BUF_EN for the zero-bubble shadow buffer.
module weight_bit_serializer #(
  parameter int M  = 16,
  parameter int Pw = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M*Pw-1:0] in_weights,
  input  logic            hold,
  output logic [M-1:0]    out_bits,
  output logic            w_en,
  output logic            MSB_w,
  output logic            busy
);

  localparam int KW = (Pw > 1) ? $clog2(Pw) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(Pw - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [M*Pw-1:0]   main_q, main_d;
  logic [M-1:0]      out_bits_q, out_bits_d;
  logic              w_en_q, w_en_d;
  logic              msb_w_q, msb_w_d;

  logic [M*Pw-1:0]   main_shifted;
  logic [M-1:0]      plane;
  logic              accept;
  logic              last_plane;

`ifdef WBS_DOUBLE_BUF_EN
  logic [M*Pw-1:0]   shadow_q, shadow_d;
  logic              shadow_valid_q, shadow_valid_d;

  assign in_ready = !shadow_valid_q;
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept     = in_valid && in_ready;
  assign last_plane = (k_q == K_LAST);

  // Each lane shifts right once per issued plane, so the current plane is always bit 0 of every lane.
  always_comb begin
    main_shifted = '0;
    plane        = '0;
    for (int unsigned i = 0; i < M; i++) begin
      plane[i]                 = main_q[i*Pw];
      main_shifted[i*Pw +: Pw] = main_q[i*Pw +: Pw] >> 1;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    main_d     = main_q;
    out_bits_d = out_bits_q;
    w_en_d     = 1'b0;
    msb_w_d    = 1'b0;
`ifdef WBS_DOUBLE_BUF_EN
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          main_d  = in_weights;
          k_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
`ifdef WBS_DOUBLE_BUF_EN
        if (accept) begin
          shadow_d       = in_weights;
          shadow_valid_d = 1'b1;
        end
`endif
        if (!hold) begin
          out_bits_d = plane;
          w_en_d     = 1'b1;
          msb_w_d    = last_plane;
          main_d     = main_shifted;
          k_d        = k_q + 1'b1;
          if (last_plane) begin
            k_d     = '0;
            state_d = IDLE;
`ifdef WBS_DOUBLE_BUF_EN
            // A queued vector continues straight into plane 0 with no idle cycle.
            if (shadow_valid_q) begin
              main_d         = shadow_q;
              shadow_valid_d = 1'b0;
              state_d        = SHIFT;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      k_q            <= '0;
      main_q         <= '0;
      out_bits_q     <= '0;
      w_en_q         <= 1'b0;
      msb_w_q        <= 1'b0;
`ifdef WBS_DOUBLE_BUF_EN
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      main_q         <= main_d;
      out_bits_q     <= out_bits_d;
      w_en_q         <= w_en_d;
      msb_w_q        <= msb_w_d;
`ifdef WBS_DOUBLE_BUF_EN
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
`endif
    end
  end

  assign out_bits = out_bits_q;
  assign w_en     = w_en_q;
  assign MSB_w    = msb_w_q;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed self-checking bench for weight_bit_serializer (M=4/Pw=4 and M=4/Pw=1 instances).
module tb_weight_bit_serializer;

`ifdef WBS_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        in_valid, in_ready, w_en, MSB_w, busy;
  logic [15:0] in_weights;
  logic [3:0]  out_bits;
  logic        in_valid1, in_ready1, w_en1, msb_w1, busy1;
  logic [3:0]  in_weights1;
  logic [3:0]  out_bits1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weight_bit_serializer #(.M(4), .Pw(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_weights(in_weights), .hold(hold), .out_bits(out_bits), .w_en(w_en),
    .MSB_w(MSB_w), .busy(busy)
  );

  weight_bit_serializer #(.M(4), .Pw(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_weights(in_weights1), .hold(hold), .out_bits(out_bits1), .w_en(w_en1),
    .MSB_w(msb_w1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_p1 [4] = '{4'b0101, 4'b0110, 4'b0111, 4'b1010};
  logic [3:0] exp_b2b [8] = '{4'b0101, 4'b0110, 4'b0111, 4'b1010,
                              4'b1010, 4'b0110, 4'b0001, 4'b0000};
  logic [3:0] planes [$];
  logic [8:0] wseq, mseq, iseq;
  int         n_acc;
  logic       acc;

  initial begin
    rst_n = 1'b0; hold = 1'b0; in_valid = 1'b0; in_weights = '0;
    in_valid1 = 1'b0; in_weights1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_bits", out_bits, 0);
    check("rst_w_en", w_en, 0);
    check("rst_msb", MSB_w, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst1_w_en", w_en1, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // single vector, no hold
    in_valid = 1'b1; in_weights = 16'h87E5;
    tick();
    in_valid = 1'b0;
    check("acc_w_en", w_en, 0);
    check("acc_busy", busy, 1);
    check("acc_ready", in_ready, DBL);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("s_plane%0d", k), out_bits, exp_p1[k]);
      check($sformatf("s_wen%0d", k), w_en, 1);
      check($sformatf("s_msb%0d", k), MSB_w, (k == 3) ? 1 : 0);
    end
    check("s_busy_end", busy, 0);
    check("s_ready_end", in_ready, 1);
    tick();
    check("s_idle_wen", w_en, 0);
    check("s_idle_msb", MSB_w, 0);
    check("s_idle_hold_bits", out_bits, 4'b1010);

    // hold for 2 cycles after plane 1
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("h_plane0", out_bits, 4'b0101);
    tick();
    check("h_plane1", out_bits, 4'b0110);
    hold = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("h_wen%0d", c), w_en, 0);
      check($sformatf("h_bits%0d", c), out_bits, 4'b0110);
      check($sformatf("h_busy%0d", c), busy, 1);
    end
    hold = 1'b0;
    tick();
    check("h_plane2", out_bits, 4'b0111);
    check("h_wen2", w_en, 1);
    check("h_msb2", MSB_w, 0);
    tick();
    check("h_plane3", out_bits, 4'b1010);
    check("h_msb3", MSB_w, 1);
    check("h_busy_end", busy, 0);
    tick();

    // two vectors back-to-back with in_valid held until both are taken
    in_weights = 16'h87E5; in_valid = 1'b1; n_acc = 0;
    planes.delete();
    acc = in_valid && in_ready;
    tick();
    if (acc) n_acc++;
    if (n_acc == 1) in_weights = 16'h1234;
    for (int j = 0; j < 9; j++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) n_acc++;
      if (n_acc >= 2) in_valid = 1'b0;
      wseq[j] = w_en;
      mseq[j] = MSB_w;
      iseq[j] = in_ready;
      if (w_en) planes.push_back(out_bits);
    end
    check("b_acc_cnt", n_acc, 2);
    check("b_wen_seq", wseq, DBL ? 9'b011111111 : 9'b111101111);
    check("b_msb_seq", mseq, DBL ? 9'b010001000 : 9'b100001000);
    check("b_ready_seq", iseq, DBL ? 9'b111111000 : 9'b100001000);
    check("b_n_planes", planes.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < planes.size()) check($sformatf("b_plane%0d", i), planes[i], exp_b2b[i]);
    repeat (2) tick();
    check("b_busy_end", busy, 0);

    // reset after plane 1
    in_valid = 1'b1; in_weights = 16'h87E5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("r_plane1", out_bits, 4'b0110);
    rst_n = 1'b0;
    #1;
    check("r_bits", out_bits, 0);
    check("r_wen", w_en, 0);
    check("r_msb", MSB_w, 0);
    check("r_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    check("r_ready", in_ready, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("r_plane0", out_bits, 4'b0101);
    check("r_wen0", w_en, 1);
    check("r_msb0", MSB_w, 0);
    repeat (4) tick();

    // Pw=1 instance
    in_valid1 = 1'b1; in_weights1 = 4'b1001;
    tick();
    in_valid1 = 1'b0;
    check("p1_busy", busy1, 1);
    check("p1_ready", in_ready1, DBL);
    tick();
    check("p1_bits", out_bits1, 4'b1001);
    check("p1_wen", w_en1, 1);
    check("p1_msb", msb_w1, 1);
    check("p1_busy_end", busy1, 0);
    tick();
    check("p1_wen_off", w_en1, 0);
    check("p1_msb_off", msb_w1, 0);
    check("p1_bits_hold", out_bits1, 4'b1001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
